// File: rtl/lisnoc_pkg.sv
// Shared LISNoC definitions: flit type encodings and the default flit layout.
// The flit type always sits in the most significant bits of a flit.
package lisnoc_pkg;

  localparam int FLIT_DATA_WIDTH = 32;
  localparam int FLIT_TYPE_WIDTH = 2;

  localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_LAST    = 2'b10;
  localparam logic [1:0] FLIT_SINGLE  = 2'b11;

  typedef struct packed {
    logic [FLIT_TYPE_WIDTH-1:0] ftype;
    logic [FLIT_DATA_WIDTH-1:0] data;
  } flit_t;

endpackage

// File: rtl/lisnoc_credit_counter.sv
// Per-VC downstream credit counter: starts full, decrements on send, increments on return.
// A return while already full saturates and raises a sticky overflow flag.
module lisnoc_credit_counter
  import lisnoc_pkg::*;
#(
  parameter int credit_depth = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dec,
  input  logic inc,
  output logic nonzero,
  output logic overflow
);

  localparam int CW = $clog2(credit_depth + 1);
  localparam logic [CW-1:0] FULL = CW'(credit_depth);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  // A send and a return in the same cycle cancel each other out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= FULL;
      overflow <= 1'b0;
    end else begin
      case ({dec, inc})
        2'b10: if (count != '0) count <= count - ONE;
        2'b01: begin
          if (count == FULL) overflow <= 1'b1;
          else               count    <= count + ONE;
        end
        default: count <= count;
      endcase
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/lisnoc_vc_credit_scheduler.sv
// Round-robin, credit-based link scheduler sharing one output link among virtual channels.
// Optional packet locking (wormhole-style, no interleaving) is enabled by LISNOC_VC_PACKET_LOCK_EN.
module lisnoc_vc_credit_scheduler
  import lisnoc_pkg::*;
#(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int vchannels       = 2,
  parameter int credit_depth    = 4,
  localparam int flit_width     = flit_data_width + flit_type_width
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [vchannels-1:0]            fifo_valid_i,
  input  logic [vchannels*flit_width-1:0] fifo_flit_i,
  output logic [vchannels-1:0]            fifo_ready_o,
  output logic [vchannels-1:0]            link_valid_o,
  output logic [flit_width-1:0]           link_flit_o,
  input  logic [vchannels-1:0]            link_credit_i,
  output logic                            credit_err_o
);

  localparam int RRW = (vchannels > 1) ? $clog2(vchannels) : 1;

  logic [vchannels-1:0]  credit_nz;
  logic [vchannels-1:0]  credit_ovf;
  logic [vchannels-1:0]  allowed;
  logic [vchannels-1:0]  elig;
  logic [vchannels-1:0]  grant;
  logic [RRW-1:0]        rr;
  logic [RRW-1:0]        grant_idx;
  logic                  grant_any;
  logic [flit_width-1:0] grant_flit;

`ifdef LISNOC_VC_PACKET_LOCK_EN
  logic                       locked;
  logic [RRW-1:0]             lock_vc;
  logic [flit_type_width-1:0] grant_type;

  assign grant_type = grant_flit[flit_width-1 -: flit_type_width];

  // A header claims the link for its VC until the matching last flit leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      lock_vc <= '0;
    end else if (grant_any) begin
      if (grant_type == flit_type_width'(FLIT_HEADER)) begin
        locked  <= 1'b1;
        lock_vc <= grant_idx;
      end else if (grant_type == flit_type_width'(FLIT_LAST)) begin
        locked  <= 1'b0;
      end
    end
  end

  always_comb begin
    allowed = '0;
    for (int v = 0; v < vchannels; v++) begin
      allowed[v] = !locked || (lock_vc == v[RRW-1:0]);
    end
  end
`else
  assign allowed = '1;
`endif

  assign elig = fifo_valid_i & credit_nz & allowed;

  // Two passes: VCs above the pointer first, then wrap around to the pointer itself.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int v = 0; v < vchannels; v++) begin
      if (!grant_any && elig[v] && (v > int'(rr))) begin
        grant_any = 1'b1;
        grant_idx = v[RRW-1:0];
      end
    end
    for (int v = 0; v < vchannels; v++) begin
      if (!grant_any && elig[v] && (v <= int'(rr))) begin
        grant_any = 1'b1;
        grant_idx = v[RRW-1:0];
      end
    end
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign fifo_ready_o = rst_n ? grant : '0;

  always_comb begin
    grant_flit = '0;
    for (int v = 0; v < vchannels; v++) begin
      if (grant[v]) grant_flit = grant_flit | fifo_flit_i[v*flit_width +: flit_width];
    end
  end

  for (genvar v = 0; v < vchannels; v++) begin : g_credit
    lisnoc_credit_counter #(
      .credit_depth(credit_depth)
    ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .dec      (fifo_ready_o[v]),
      .inc      (link_credit_i[v]),
      .nonzero  (credit_nz[v]),
      .overflow (credit_ovf[v])
    );
  end

  assign credit_err_o = |credit_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      link_valid_o <= '0;
      link_flit_o  <= '0;
    end else if (grant_any) begin
      link_valid_o <= grant;
      link_flit_o  <= grant_flit;
    end else begin
      link_valid_o <= '0;
    end
  end

  // The pointer resets to the last VC so VC0 wins the first arbitration.
  if (vchannels > 1) begin : g_rr
    always_ff @(posedge clk) begin
      if (!rst_n)         rr <= RRW'(vchannels - 1);
      else if (grant_any) rr <= grant_idx;
    end
  end else begin : g_rr_fixed
    assign rr = '0;
  end

endmodule

// File: tb/tb_lisnoc_vc_credit_scheduler.sv
// Self-checking bench for lisnoc_vc_credit_scheduler (vchannels=2, credit_depth=4) against a queue-based reference model.
// Define LISNOC_VC_PACKET_LOCK_EN for both RTL and bench to exercise packet locking.
module tb_lisnoc_vc_credit_scheduler;
  import lisnoc_pkg::*;

  localparam int NVC   = 2;
  localparam int DEPTH = 4;
  localparam int FW    = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NVC-1:0]    fifo_valid_i;
  logic [NVC*FW-1:0] fifo_flit_i;
  logic [NVC-1:0]    fifo_ready_o;
  logic [NVC-1:0]    link_valid_o;
  logic [FW-1:0]     link_flit_o;
  logic [NVC-1:0]    link_credit_i;
  logic              credit_err_o;

  always #5 clk = ~clk;

  lisnoc_vc_credit_scheduler #(
    .flit_data_width(FLIT_DATA_WIDTH),
    .flit_type_width(FLIT_TYPE_WIDTH),
    .vchannels      (NVC),
    .credit_depth   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_valid_i (fifo_valid_i),
    .fifo_flit_i  (fifo_flit_i),
    .fifo_ready_o (fifo_ready_o),
    .link_valid_o (link_valid_o),
    .link_flit_o  (link_flit_o),
    .link_credit_i(link_credit_i),
    .credit_err_o (credit_err_o)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cycle   = 0;

  // Stimulus state: per-VC source FIFOs, pause mask, credit returns
  logic [FW-1:0] q0[$];
  logic [FW-1:0] q1[$];
  logic [1:0]    paused = 2'b00;
  logic [1:0]    credRet = 2'b00;
  logic          rstnDrv = 1'b0;
  bit            autoReturn = 1'b0;
  logic [FW-1:0] obsLog[$];

  // Reference model state
  int            mCred[NVC];
  int            mRr;
  bit            mErr;
  logic [1:0]    mLinkV;
  logic [FW-1:0] mLinkF;
  bit            mLocked;
  int            mLockVc;

  function automatic logic [FW-1:0] mkFlit(logic [1:0] t, logic [31:0] d);
    flit_t f;
    f.ftype = t;
    f.data  = d;
    return f;
  endfunction

  function automatic int modelGrant(logic [1:0] vld);
    for (int k = 1; k <= NVC; k++) begin
      int v = (mRr + k) % NVC;
`ifdef LISNOC_VC_PACKET_LOCK_EN
      if (mLocked && v != mLockVc) continue;
`endif
      if (vld[v] && mCred[v] > 0) return v;
    end
    return -1;
  endfunction

  task automatic checkOutput(string tag, logic [63:0] got, logic [63:0] exp);
    nChecks++;
    assert (got === exp) else begin
      nFails++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  // One clock cycle: drive, check the combinational grant, clock, advance model, check registers.
  task automatic applyStimulus();
    logic [1:0]    vld;
    logic [FW-1:0] h0, h1;
    logic [1:0]    expReady;
    int            g;
    vld[0] = (q0.size() > 0) && !paused[0];
    vld[1] = (q1.size() > 0) && !paused[1];
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    if (autoReturn) credRet = mLinkV;
    rst_n         = rstnDrv;
    fifo_valid_i  = vld;
    fifo_flit_i   = {h1, h0};
    link_credit_i = credRet;
    #2;
    g = rstnDrv ? modelGrant(vld) : -1;
    expReady = (g >= 0) ? (2'b01 << g) : 2'b00;
    checkOutput("fifo_ready", 64'(fifo_ready_o), 64'(expReady));
    @(posedge clk);
    #1;
    cycle++;
    if (!rstnDrv) begin
      mCred   = '{DEPTH, DEPTH};
      mRr     = NVC - 1;
      mErr    = 1'b0;
      mLinkV  = '0;
      mLinkF  = '0;
      mLocked = 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        bit send = (g == v);
        bit ret  = credRet[v];
        if (send && !ret) mCred[v]--;
        else if (!send && ret) begin
          if (mCred[v] == DEPTH) mErr = 1'b1;
          else mCred[v]++;
        end
      end
      if (g >= 0) begin
        mLinkF = (g == 0) ? h0 : h1;
        mLinkV = 2'b01 << g;
        mRr    = g;
`ifdef LISNOC_VC_PACKET_LOCK_EN
        if (mLinkF[FW-1 -: 2] == FLIT_HEADER) begin
          mLocked = 1'b1;
          mLockVc = g;
        end else if (mLinkF[FW-1 -: 2] == FLIT_LAST) begin
          mLocked = 1'b0;
        end
`endif
        if (g == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end else begin
        mLinkV = '0;
      end
    end
    checkOutput("link_valid", 64'(link_valid_o), 64'(mLinkV));
    checkOutput("link_flit", 64'(link_flit_o), 64'(mLinkF));
    checkOutput("credit_err", 64'(credit_err_o), 64'(mErr));
    if (link_valid_o != '0) obsLog.push_back(link_flit_o);
  endtask

  task automatic runCycles(int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic resetPhase(int n);
    q0.delete();
    q1.delete();
    paused     = 2'b00;
    credRet    = 2'b00;
    autoReturn = 1'b0;
    rstnDrv    = 1'b0;
    runCycles(n);
    rstnDrv    = 1'b1;
  endtask

  initial begin
    // Reset state
    resetPhase(2);

    // VC0 alone, no credits back: four grants then starvation
    for (int i = 0; i < 6; i++) q0.push_back(mkFlit(FLIT_PAYLOAD, 32'h1000 + i));
    runCycles(6);

    // Both VCs busy, credits returned as flits leave: strict alternation
    resetPhase(1);
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mkFlit(FLIT_PAYLOAD, 32'hA000 + i));
      q1.push_back(mkFlit(FLIT_PAYLOAD, 32'hB000 + i));
    end
    autoReturn = 1'b1;
    runCycles(8);
    autoReturn = 1'b0;
    credRet    = 2'b00;

    // VC1 drained to zero, then one credit makes it eligible a cycle later
    resetPhase(1);
    for (int i = 0; i < 6; i++) q1.push_back(mkFlit(FLIT_PAYLOAD, 32'hC000 + i));
    runCycles(4);
    credRet = 2'b10;
    runCycles(1);
    credRet = 2'b00;
    runCycles(2);

    // Send and return together at 2 credits, then refill past full
    resetPhase(1);
    q0.push_back(mkFlit(FLIT_PAYLOAD, 32'hD000));
    q0.push_back(mkFlit(FLIT_PAYLOAD, 32'hD001));
    runCycles(2);
    q0.push_back(mkFlit(FLIT_PAYLOAD, 32'hD002));
    credRet = 2'b01;
    runCycles(1);
    runCycles(3);
    credRet = 2'b00;
    runCycles(3);

    // Mid-stream reset with credits at 1/3
    resetPhase(1);
    for (int i = 0; i < 6; i++) q0.push_back(mkFlit(FLIT_PAYLOAD, 32'hE000 + i));
    q1.push_back(mkFlit(FLIT_PAYLOAD, 32'hE100));
    runCycles(4);
    q1.push_back(mkFlit(FLIT_PAYLOAD, 32'hE101));
    q1.push_back(mkFlit(FLIT_PAYLOAD, 32'hE102));
    rstnDrv = 1'b0;
    runCycles(1);
    rstnDrv = 1'b1;
    runCycles(4);

`ifdef LISNOC_VC_PACKET_LOCK_EN
    // Packet lock: VC0 H,P,(pause),L must not interleave with VC1 SINGLE
    resetPhase(1);
    q0.push_back(mkFlit(FLIT_HEADER,  32'h0000_00A1));
    q0.push_back(mkFlit(FLIT_PAYLOAD, 32'h0000_00A2));
    q0.push_back(mkFlit(FLIT_LAST,    32'h0000_00A3));
    q1.push_back(mkFlit(FLIT_SINGLE,  32'h0000_00B1));
    obsLog.delete();
    runCycles(2);
    paused = 2'b01;
    runCycles(2);
    paused = 2'b00;
    runCycles(3);
    checkOutput("lock_count", 64'(obsLog.size()), 64'd4);
    if (obsLog.size() == 4) begin
      checkOutput("lock_order0", 64'(obsLog[0]), 64'(mkFlit(FLIT_HEADER,  32'h0000_00A1)));
      checkOutput("lock_order1", 64'(obsLog[1]), 64'(mkFlit(FLIT_PAYLOAD, 32'h0000_00A2)));
      checkOutput("lock_order2", 64'(obsLog[2]), 64'(mkFlit(FLIT_LAST,    32'h0000_00A3)));
      checkOutput("lock_order3", 64'(obsLog[3]), 64'(mkFlit(FLIT_SINGLE,  32'h0000_00B1)));
    end
`endif

    // Randomized traffic, pauses and legal credit returns
    resetPhase(1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 6)
        q0.push_back(mkFlit(2'($urandom_range(0, 3)), $urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 6)
        q1.push_back(mkFlit(2'($urandom_range(0, 3)), $urandom));
      paused[0]  = ($urandom_range(0, 4) == 0);
      paused[1]  = ($urandom_range(0, 4) == 0);
      credRet[0] = ($urandom_range(0, 1) == 1) && (mCred[0] < DEPTH);
      credRet[1] = ($urandom_range(0, 1) == 1) && (mCred[1] < DEPTH);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/lisnoc_vc_credit_scheduler.md
Name: lisnoc_vc_credit_scheduler

Overview:
Credit-based link scheduler for a router output port. It shares one physical link between `vchannels` virtual-channel FIFOs. Per-VC credit counters track free slots in the downstream input buffers, and each cycle the block grants one VC round-robin among those with both a valid flit and a credit. The granted flit is registered onto the link; the downstream router returns credits as one-cycle pulses.

Parameters:
- flit_data_width, 32, payload bits per flit
- flit_type_width, 2, flit type bits; flit_width = data + type, type in the MSBs
- vchannels, 2, number of virtual channels (>=1)
- credit_depth, 4, downstream buffer depth per VC (>=1); reset value of each credit counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- fifo_valid_i  in  vchannels  per-VC flit available
- fifo_flit_i  in  vchannels*flit_width  per-VC flits, VC v at [(v+1)*flit_width-1 : v*flit_width]
- fifo_ready_o  out  vchannels  one-hot grant; flit consumed this cycle
- link_valid_o  out  vchannels  registered one-hot VC tag of the flit on the link
- link_flit_o  out  flit_width  registered flit
- link_credit_i  in  vchannels  credit-return pulses, one slot freed per asserted bit per cycle
- credit_err_o  out  1  sticky: a credit was returned while the counter was already at credit_depth

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - credit[v] = credit_depth
  - rr pointer = vchannels-1, so VC0 has first priority
  - link_valid_o = 0, link_flit_o = 0, credit_err_o = 0
  - fifo_ready_o forced to 0 combinationally while rst_n=0
  - Reset mid-operation drops any in-flight registered flit and restores full credits.
- Eligibility: elig[v] = fifo_valid_i[v] & (credit[v] != 0).
- Arbitration (combinational, same cycle):
  - Search from rr+1 upward, wrapping at vchannels; the first eligible VC g is granted.
  - fifo_ready_o = onehot(g) if any VC is eligible, else 0.
  - At most one bit of fifo_ready_o is ever set.
- On a clk edge with a grant:
  - link_flit_o <= fifo_flit_i[g]
  - link_valid_o <= onehot(g)
  - rr <= g
- Without a grant: link_valid_o <= 0, link_flit_o holds, rr holds.
- Latency: exactly 1 cycle from grant to the flit appearing on the link. The link has no ready; the credits are the flow control.
- Credit arithmetic per VC, counter width $clog2(credit_depth+1):
  - send only: -1
  - return only: +1
  - send and return in the same cycle: unchanged
  - return at credit_depth with no send: counter saturates and credit_err_o is set; it clears only on reset.
- A counter can never underflow, because no grant is issued at 0 credits.
- A credit returned in cycle t makes the VC eligible in cycle t+1; there is no combinational credit-to-grant path.
- vchannels=1: rr is a constant 0 and no pointer logic is needed.

Optional Feature:
LISNOC_VC_PACKET_LOCK_EN
- Defined:
  - A grant of a HEADER flit (type 2'b01) locks the scheduler to that VC.
  - While locked, only the locked VC is eligible; if it lacks a valid flit or a credit, the link idles.
  - The lock releases on the clk edge where that VC's LAST flit (2'b10) is granted.
  - SINGLE (2'b11) never locks.
  - Reset clears the lock.
- Undefined: flit-level round-robin; flits of different packets may interleave across VCs.

Decomposition:
- Shared package lisnoc_pkg:
  - flit type constants FLIT_PAYLOAD=2'b00, FLIT_HEADER=2'b01, FLIT_LAST=2'b10, FLIT_SINGLE=2'b11
  - a flit struct typedef (type, data)
- One natural sub-module: lisnoc_credit_counter, per-VC instance. Inputs are dec, inc and rst_n; outputs are nonzero and overflow. It is parameterised by credit_depth.

Test Plan:
- vchannels=2, credit_depth=4, VC0 valid continuously, no credits returned:
  - fifo_ready_o=01 for 4 consecutive cycles, then 00
  - link_valid_o=01 on cycles 1..4
  - credit[0]=0 afterwards
- Both VCs valid, credits returned every cycle: grants alternate 01,10,01,10; link_flit_o equals the granted VC's flit one cycle later.
- VC1 at 0 credits: pulse link_credit_i=10 at cycle t; fifo_ready_o[1]=1 at t+1, not at t.
- Simultaneous send and credit return on VC0 at 2 credits: the counter stays at 2. A return at 4 credits with no send sets credit_err_o=1, which stays set until rst_n=0.
- Assert rst_n=0 for 1 cycle mid-stream with credits at 1/3: next cycle link_valid_o=00 and credits are 4/4; the first grant after reset goes to VC0.
- With LISNOC_VC_PACKET_LOCK_EN, VC0 sends HEADER,PAYLOAD,LAST and VC1 sends SINGLE, all valid:
  - link order is VC0 H,P,L then VC1 S
  - pausing VC0 valid mid-packet idles the link: link_valid_o=00 while VC1 waits
